// File: rtl/mc_controller.sv
// mc_controller: multi-cycle RV32I control unit with a Moore main FSM whose
// decoded controls are registered, plus combinational immSrc and ALU decoders.
module mc_controller #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         op,
   input  logic [2:0]         funct3,
   input  logic               funct7b5,
   input  logic               zero,
   output logic               pcWrite,
   output logic               adrSrc,
   output logic               memWrite,
   output logic               irWrite,
   output logic [1:0]         resultSrc,
   output logic [1:0]         aluSrcA,
   output logic [1:0]         aluSrcB,
   output logic               regWrite,
   output logic [2:0]         immSrc,
   output logic [2:0]         aluControl,
   output logic               illegal,
   output logic [STATE_W-1:0] state_o
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR,
      ALUWB, EXECI, JAL, BRANCH, LUI, AUIPC
   } state_t;

   // alu_op: 00 add, 01 sub, 10 decode from funct fields
   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       decode;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic [1:0] alu_op;
   } ctrl_t;

   function automatic ctrl_t ctrl_of(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:   begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
         DECODE:  begin c.decode = 1'b1; c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
         MEMADR:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
         MEMRD:   c.adr_src = 1'b1;
         MEMWB:   begin c.result_src = 2'b01; c.reg_write = 1'b1; end
         MEMWR:   begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
         EXECR:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
         ALUWB:   c.reg_write = 1'b1;
         EXECI:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
         JAL:     begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
         BRANCH:  begin c.branch = 1'b1; c.alu_src_a = 2'b10; c.alu_op = 2'b01; end
         LUI:     begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b01; end
         AUIPC:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
         default: begin c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      endcase
      return c;
   endfunction

   state_t state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic   legal_op;

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE:
            case (op)
               7'b0000011, 7'b0100011: state_d = MEMADR;
               7'b0110011:             state_d = EXECR;
               7'b0010011:             state_d = EXECI;
               7'b1100011:             state_d = BRANCH;
               7'b1101111:             state_d = JAL;
               7'b0110111:             state_d = LUI;
               7'b0010111:             state_d = AUIPC;
               default:                state_d = FETCH;
            endcase
         MEMADR: state_d = op[5] ? MEMWR : MEMRD;
         MEMRD:  state_d = MEMWB;
         EXECR, EXECI, JAL, LUI, AUIPC: state_d = ALUWB;
         default: state_d = FETCH;
      endcase
      ctrl_d = ctrl_of(state_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         ctrl_q  <= ctrl_of(FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   always_comb begin
      legal_op = op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                            7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};
      case (op)
         7'b0100011:             immSrc = 3'b001;
         7'b1100011:             immSrc = 3'b010;
         7'b1101111:             immSrc = 3'b011;
         7'b0110111, 7'b0010111: immSrc = 3'b100;
         default:                immSrc = 3'b000;
      endcase
      aluControl = {2'b00, ctrl_q.alu_op[0]};
      if (ctrl_q.alu_op[1])
         case (funct3)
            3'b000:  aluControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
            3'b010:  aluControl = 3'b101;
            3'b110:  aluControl = 3'b011;
            3'b111:  aluControl = 3'b010;
            default: aluControl = 3'b000;
         endcase
   end

   // Strobes are gated by rst_n so a reset mid-instruction silences them at once
   assign pcWrite   = rst_n & (ctrl_q.pc_write |
                      (ctrl_q.branch & (funct3[2:1] == 2'b00) & (zero ^ funct3[0])));
   assign irWrite   = rst_n & ctrl_q.ir_write;
   assign regWrite  = rst_n & ctrl_q.reg_write;
   assign memWrite  = rst_n & ctrl_q.mem_write;
   assign illegal   = rst_n & ctrl_q.decode & ~legal_op;
   assign adrSrc    = ctrl_q.adr_src;
   assign resultSrc = ctrl_q.result_src;
   assign aluSrcA   = ctrl_q.alu_src_a;
   assign aluSrcB   = ctrl_q.alu_src_b;
   assign state_o   = STATE_W'(state_q);
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized instruction stream checked against a
// reference built from per-class latencies and the per-state control table.
module tb_mc_controller;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [6:0] op = '0;
   logic [2:0] funct3 = '0;
   logic       funct7b5 = 1'b0, zero = 1'b0;
   logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
   logic [1:0] resultSrc, aluSrcA, aluSrcB;
   logic [2:0] immSrc, aluControl;
   logic [3:0] state_o;
   int total = 0, bad = 0;

   mc_controller #(.STATE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite),
      .irWrite(irWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
      .regWrite(regWrite), .immSrc(immSrc), .aluControl(aluControl),
      .illegal(illegal), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int lat(input logic [6:0] o);
      case (o)
         7'b0000011: return 5;
         7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b0110111, 7'b0010111: return 4;
         7'b1100011: return 3;
         default:    return 2;
      endcase
   endfunction

   function automatic int exp_state(input logic [6:0] o, input int i);
      if (i < 2) return i;
      if (i == 4) return 4;
      if (i == 3) return (o == 7'b0000011) ? 3 : (o == 7'b0100011) ? 5 : 7;
      case (o)
         7'b0000011, 7'b0100011: return 2;
         7'b0110011: return 6;
         7'b0010011: return 8;
         7'b1100011: return 10;
         7'b1101111: return 9;
         7'b0110111: return 11;
         default:    return 12;
      endcase
   endfunction

   // {adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB, regWrite}
   function automatic logic [10:0] exp_ctrl(input int s);
      case (s)
         0:  return {1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0};
         1:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0};
         2:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0};
         3:  return {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
         4:  return {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1};
         5:  return {1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
         6:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0};
         7:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1};
         8:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0};
         9:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0};
         10: return {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0};
         11: return {1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 1'b0};
         default: return {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0};
      endcase
   endfunction

   function automatic logic [2:0] exp_imm(input logic [6:0] o);
      case (o)
         7'b0100011: return 3'b001;
         7'b1100011: return 3'b010;
         7'b1101111: return 3'b011;
         7'b0110111, 7'b0010111: return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] exp_alu(input int s, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7);
      if (s == 10) return 3'b001;
      if (s != 6 && s != 8) return 3'b000;
      case (f3)
         3'b000: return (o[5] && f7) ? 3'b001 : 3'b000;
         3'b010: return 3'b101;
         3'b110: return 3'b011;
         3'b111: return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Called on a falling edge; leaves on the falling edge after the last cycle run
   task automatic run_instr(input logic [31:0] w, input int zmode, input int stop);
      int n, s;
      logic pc_exp;
      n = (stop > 0) ? stop : lat(w[6:0]);
      for (int i = 0; i < n; i++) begin
         op = w[6:0];
         funct3 = w[14:12];
         funct7b5 = w[30];
         zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         #1;
         s = exp_state(w[6:0], i);
         pc_exp = (s == 0 || s == 9) ? 1'b1 :
                  (s == 10 && w[13] == 1'b0 && w[14] == 1'b0) ? (zero ^ w[12]) : 1'b0;
         chk($sformatf("state %08h c%0d", w, i), state_o, s);
         chk($sformatf("ctrl %08h s%0d", w, s),
             {adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB, regWrite}, exp_ctrl(s));
         chk($sformatf("pcWrite %08h s%0d", w, s), pcWrite, pc_exp);
         chk($sformatf("immSrc %08h", w), immSrc, exp_imm(w[6:0]));
         chk($sformatf("aluControl %08h s%0d", w, s), aluControl,
             exp_alu(s, w[6:0], w[14:12], w[30]));
         chk($sformatf("illegal %08h s%0d", w, s), illegal, (s == 1 && lat(w[6:0]) == 2));
         @(negedge clk);
      end
   endtask

   logic [6:0] ops [11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b0110111, 7'b0010111, 7'b1100111, 7'b0000000,
                            7'b1111111};

   initial begin
      logic [31:0] w;
      repeat (2) @(negedge clk);
      #1;
      chk("reset state", state_o, 0);
      chk("reset strobes", {pcWrite, irWrite, regWrite, memWrite, illegal}, 5'b0);
      chk("reset selects", {adrSrc, resultSrc, aluSrcA, aluSrcB}, 7'b0_10_00_10);
      @(negedge clk);
      rst_n = 1'b1;
      run_instr(32'h00402083, -1, 0);
      run_instr(32'h0010A223, -1, 0);
      run_instr(32'h40208033, -1, 0);
      run_instr(32'h0020E033, -1, 0);
      run_instr(32'h00208463, 1, 0);
      run_instr(32'h00208463, 0, 0);
      run_instr(32'h00209463, 0, 0);
      run_instr(32'h00209463, 1, 0);
      run_instr(32'h123450B7, -1, 0);
      run_instr(32'h00000000, -1, 0);
      // Reset asserted while the store is in MEMWR
      run_instr(32'h0010A223, -1, 3);
      #1;
      chk("pre-reset state", state_o, 5);
      chk("pre-reset memWrite", memWrite, 1);
      rst_n = 1'b0;
      #1;
      chk("abort memWrite", memWrite, 0);
      chk("abort state", state_o, 0);
      chk("abort strobes", {pcWrite, irWrite, regWrite, illegal}, 4'b0);
      chk("abort selects", {adrSrc, resultSrc, aluSrcA, aluSrcB}, 7'b0_10_00_10);
      @(negedge clk);
      rst_n = 1'b1;
      run_instr(32'h00000000, -1, 0);
      for (int k = 0; k < 200; k++) begin
         w = $urandom;
         w[6:0] = ops[$urandom_range(0, 10)];
         if (k % 10 == 9) w[6:0] = 7'($urandom);
         run_instr(w, -1, 0);
      end
      #1;
      chk("final state", state_o, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control unit for the RV32I multi-cycle processor.
- Takes opcode/funct fields from the instruction register (IR) and the ALU `zero` flag.
- Drives every datapath strobe and mux select, including the 3-bit `immSrc` for the immediate extender.
- Contains a Moore main FSM, a combinational immediate-type decoder and an ALU decoder.

Parameters:
- STATE_W, 4, width of state register and `state_o`.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- op  in  7  instr[6:0] from IR.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag, valid in the BRANCH cycle.
- pcWrite  out  1  PC register enable.
- adrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memWrite  out  1  data memory write strobe.
- irWrite  out  1  IR / OldPC load enable.
- resultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- aluSrcA  out  2  A select: 00 = PC, 01 = OldPC, 10 = RD1 register, 11 = constant 0.
- aluSrcB  out  2  B select: 00 = RD2 register, 01 = immExt, 10 = constant 4.
- regWrite  out  1  register file write enable.
- immSrc  out  3  immediate-type select to the extender.
- aluControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- state_o  out  STATE_W  current state, for debug.

Behaviour:
State register and reset:
- Reset is asynchronous and active-low; it drives state to FETCH (0).
- While rst_n = 0, pcWrite, irWrite, regWrite, memWrite and illegal are forced to 0 combinationally.
- While rst_n = 0, the select outputs take their FETCH values.
- Reset asserted mid-instruction aborts it immediately; no strobe fires after rst_n falls.
- After release, the first clock edge executes FETCH.

Outputs:
- All outputs are Moore decodes of state, except pcWrite (depends on `zero` in BRANCH) and immSrc/aluControl (decoded from the instruction fields).
- Unlisted strobes are 0; unlisted selects are 00.

State encoding, outputs and next state:
- 0 FETCH: adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, add, resultSrc=10, pcWrite=1 → DECODE.
- 1 DECODE: aluSrcA=01, aluSrcB=01, add (branch target into ALUOut). Next state by op:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - 0010111 → AUIPC
  - otherwise: illegal=1 → FETCH
- 2 MEMADR: aluSrcA=10, aluSrcB=01, add → MEMRD if op[5]=0, else MEMWR.
- 3 MEMRD: adrSrc=1 → MEMWB.
- 4 MEMWB: resultSrc=01, regWrite=1 → FETCH.
- 5 MEMWR: adrSrc=1, memWrite=1 → FETCH.
- 6 EXECR: aluSrcA=10, aluSrcB=00, ALU-decoded op → ALUWB.
- 7 ALUWB: resultSrc=00, regWrite=1 → FETCH.
- 8 EXECI: aluSrcA=10, aluSrcB=01, ALU-decoded op → ALUWB.
- 9 JAL: aluSrcA=01, aluSrcB=10, add, resultSrc=00, pcWrite=1 → ALUWB.
- 10 BRANCH: aluSrcA=10, aluSrcB=00, sub, resultSrc=00 → FETCH.
  - pcWrite = zero XOR funct3[0] (beq / bne).
  - Other funct3 values: pcWrite=0.
- 11 LUI: aluSrcA=11, aluSrcB=01, add → ALUWB.
- 12 AUIPC: aluSrcA=01, aluSrcB=01, add → ALUWB.
- Codes 13–15: behave as FETCH with all strobes 0, then → FETCH.

Latency in cycles:
- Load: 5.
- Store, R-type, I-type ALU, JAL, LUI, AUIPC: 4.
- Branch: 3.
- Illegal opcode: 2.

immSrc, decoded from op in every state:
- 0000011 / 0010011 / 1100111 → 000
- 0100011 → 001
- 1100011 → 010
- 1101111 → 011
- 0110111 / 0010111 → 100
- otherwise → 000

aluControl:
- FETCH, DECODE, MEMADR, JAL, LUI, AUIPC: add.
- BRANCH: sub.
- EXECR / EXECI, decoded by funct3:
  - 000: sub if op[5] & funct7b5, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - any other: add.

Test Plan:
- Reset: rst_n=0 in MEMWR → memWrite=0 immediately, state_o=0; release, one edge → DECODE.
- Load, 0x00402083 (lw x1,4(x0)): states 0,1,2,3,4,0; regWrite=1 only in state 4 with resultSrc=01; immSrc=000.
- Store, 0x0010A223 (sw): states 0,1,2,5,0; memWrite=1 only in state 5, adrSrc=1; immSrc=001.
- R-type, 0x40208033 (sub): aluControl=001 in EXECR. Then 0x0020E033 (or): aluControl=011; regWrite in ALUWB.
- Branch, 0x00208463 (beq): zero=1 → pcWrite=1 in BRANCH, immSrc=010. zero=0 → pcWrite=0. bne with zero=0 → pcWrite=1.
- LUI / illegal: 0x123450B7 (lui) → aluSrcA=11, aluSrcB=01, immSrc=100, states 0,1,11,7,0. op=0000000 → illegal pulse in DECODE, back to FETCH, no regWrite.
